// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them to consecutive IMEM addresses, then verifies an XOR checksum.
module imem_loader #(
  parameter int addr_data_width = 32,
  parameter int IMEM_DEPTH      = 512,
  parameter int IMEM_AW         = $clog2(IMEM_DEPTH)
) (
  input  logic                       clk1,
  input  logic                       reset1,
  input  logic                       start,
  input  logic [IMEM_AW:0]           word_count,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  output logic                       imem_we,
  output logic [IMEM_AW-1:0]         imem_waddr,
  output logic [addr_data_width-1:0] imem_wdata,
  output logic                       core_hold,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [IMEM_AW:0] DEPTH_W = (IMEM_AW+1)'(IMEM_DEPTH);

  state_t                     state_q, state_d;
  logic [IMEM_AW:0]           wcnt_q, wcnt_d;
  logic [IMEM_AW:0]           widx_q, widx_d;
  logic [1:0]                 bidx_q, bidx_d;
  logic [addr_data_width-1:0] word_q, word_d;
  logic [7:0]                 csum_q, csum_d;
  logic                       accept;

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
    end
  end

  // Outputs decode only the state register, so byte_valid never reaches byte_ready.
  assign byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
  assign imem_we    = (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign core_hold  = (state_q != S_DONE);
  assign imem_waddr = widx_q[IMEM_AW-1:0];
  assign imem_wdata = word_q;
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    csum_d  = csum_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          wcnt_d = word_count;
          widx_d = '0;
          bidx_d = '0;
          csum_d = '0;
          if (word_count > DEPTH_W)   state_d = S_ERR;
          else if (word_count == '0)  state_d = S_CHECK;
          else                        state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (accept) begin
          word_d[{bidx_q, 3'b000} +: 8] = byte_data;
          csum_d = csum_q ^ byte_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        widx_d  = widx_q + 1'b1;
        state_d = (widx_d == wcnt_q) ? S_CHECK : S_RECV;
      end
      S_CHECK: begin
        // The checksum byte itself is compared, never folded into the XOR.
        if (accept) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected IMEM writes queued as bytes are driven,
// popped and compared whenever the loader pulses imem_we.
module tb_imem_loader;

  logic        clk1 = 1'b0;
  logic        reset1;
  logic        start;
  logic [9:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, core_hold, done, err;
  logic [8:0]  imem_waddr;
  logic [31:0] imem_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [8:0] addr; logic [31:0] data; } wr_t;
  wr_t sb[$];

  logic [7:0] stream [8] = '{8'hb3, 8'h82, 8'h41, 8'h00, 8'h33, 8'h83, 8'h41, 8'h40};

  imem_loader dut (
    .clk1(clk1), .reset1(reset1), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and score any write pulse seen there.
  task automatic step();
    wr_t e;
    @(negedge clk1);
    if (imem_we !== 1'b0) begin
      if (sb.size() == 0) chk("we_unexpected", {31'd0, imem_we}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("waddr", {23'd0, imem_waddr}, {23'd0, e.addr});
        chk("wdata", imem_wdata, e.data);
      end
    end
  endtask

  task automatic do_start(input logic [9:0] n);
    start = 1'b1;
    word_count = n;
    step();
    start = 1'b0;
    word_count = 10'h3ff;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    logic rdy;
    int   n;
    byte_valid = 1'b0;
    repeat ($urandom_range(0, maxgap)) step();
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    do begin
      rdy = byte_ready;
      step();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("byte_timeout", {31'd0, byte_ready}, 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic push_words();
    sb.push_back('{9'd0, 32'h004182b3});
    sb.push_back('{9'd1, 32'h40418333});
  endtask

  task automatic send_stream(input int nbytes, input int maxgap);
    for (int i = 0; i < nbytes; i++) send_byte(stream[i], maxgap);
  endtask

  initial begin
    reset1 = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
    step(); step();
    chk("rst_core_hold", {31'd0, core_hold}, 32'd1);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_waddr", {23'd0, imem_waddr}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    reset1 = 1'b0;
    step();
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);

    // Two-word load with good checksum.
    do_start(10'd2);
    chk("s1_ready", {31'd0, byte_ready}, 32'd1);
    chk("s1_hold", {31'd0, core_hold}, 32'd1);
    push_words();
    send_stream(8, 0);
    send_byte(8'hc1, 0);
    chk("s1_done", {31'd0, done}, 32'd1);
    chk("s1_err", {31'd0, err}, 32'd0);
    chk("s1_hold_low", {31'd0, core_hold}, 32'd0);
    chk("s1_sb_empty", sb.size(), 32'd0);
    step();
    chk("s1_done_sticky", {31'd0, done}, 32'd1);

    // Bad checksum.
    do_start(10'd2);
    chk("s2_hold", {31'd0, core_hold}, 32'd1);
    push_words();
    send_stream(8, 0);
    send_byte(8'h00, 0);
    chk("s2_err", {31'd0, err}, 32'd1);
    chk("s2_done", {31'd0, done}, 32'd0);
    chk("s2_hold", {31'd0, core_hold}, 32'd1);
    chk("s2_sb_empty", sb.size(), 32'd0);

    // Empty load: only the checksum byte.
    do_start(10'd0);
    chk("s3_ready", {31'd0, byte_ready}, 32'd1);
    send_byte(8'h00, 0);
    chk("s3_done", {31'd0, done}, 32'd1);
    step(); step();
    chk("s3_done_sticky", {30'd0, done, err}, 32'd2);

    // Overflow at start.
    do_start(10'd513);
    chk("s4_err", {31'd0, err}, 32'd1);
    chk("s4_ready", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b1; byte_data = 8'h5a;
    repeat (4) step();
    byte_valid = 1'b0;
    chk("s4_err_sticky", {31'd0, err}, 32'd1);
    chk("s4_hold", {31'd0, core_hold}, 32'd1);

    // Full-depth boundary start is legal.
    do_start(10'd512);
    chk("s4b_recv", {30'd0, byte_ready, err}, 32'd2);

    // Reset mid-load after 6 of 8 bytes: first word already committed.
    sb.push_back('{9'd0, 32'h004182b3});
    send_stream(6, 0);
    chk("s6_sb_first", sb.size(), 32'd0);
    #1 reset1 = 1'b1;
    #1;
    chk("s6_async_ready", {31'd0, byte_ready}, 32'd0);
    chk("s6_async_hold", {31'd0, core_hold}, 32'd1);
    chk("s6_async_waddr", {23'd0, imem_waddr}, 32'd0);
    step();
    reset1 = 1'b0;
    step();
    chk("s6_idle_done", {30'd0, done, err}, 32'd0);
    do_start(10'd2);
    push_words();
    send_stream(8, 0);
    send_byte(8'hc1, 0);
    chk("s6_done", {31'd0, done}, 32'd1);
    chk("s6_sb_empty", sb.size(), 32'd0);

    // Random gaps and bytes offered during the write bubble.
    do_start(10'd2);
    push_words();
    send_stream(8, 3);
    send_byte(8'hc1, 3);
    chk("s5_done", {31'd0, done}, 32'd1);
    chk("s5_hold", {31'd0, core_hold}, 32'd0);
    chk("s5_sb_empty", sb.size(), 32'd0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory loader for the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles bytes little-endian into 32-bit instructions. It writes each instruction into the instruction memory write port at consecutive word addresses. It holds the core in reset until the whole image has been loaded and its checksum verified, so it is the writer for the word-indexed memory the fetch stage reads (PC increments by 1 per instruction).

## Interface
- addr_data_width, 32, instruction/data width; fixed at 32, the block assumes 4 bytes per word
- IMEM_DEPTH, 512, number of instruction words in instruction memory
- IMEM_AW, 9, word-address width, equal to clog2(IMEM_DEPTH)

- clk1  input  1  clock; all state updates on the rising edge
- reset1  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- word_count  input  IMEM_AW+1  number of words to load; sampled on the cycle start is accepted
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction memory write enable, one cycle per word
- imem_waddr  output  IMEM_AW  word address to write
- imem_wdata  output  addr_data_width  assembled instruction
- core_hold  output  1  drives the core's reset1; 1 keeps PC at 0
- done  output  1  load complete and checksum good
- err  output  1  load failed (overflow or checksum mismatch)

## Operation
- A byte is accepted on any rising edge where byte_valid && byte_ready.
- States and outputs:
  - IDLE: byte_ready=0, core_hold=1.
  - RECV: byte_ready=1.
  - WRITE: byte_ready=0, imem_we=1.
  - CHECK: byte_ready=1.
  - DONE: done=1, core_hold=0.
  - ERR: err=1, core_hold=1.
- Reset:
  - State IDLE; all counters, the word register and the checksum are 0.
  - Outputs: core_hold=1, byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, done=0, err=0.
- Start from IDLE, DONE or ERR:
  - Latch word_count, clear the word index, byte index and checksum, and set core_hold=1.
  - word_count > IMEM_DEPTH → ERR.
  - word_count == 0 → CHECK.
  - Otherwise → RECV.
- Start in RECV, WRITE or CHECK is ignored.
- RECV:
  - Accepted byte k (k = 0..3) goes into wdata[8k+7:8k].
  - The running checksum XORs every accepted data byte.
  - After byte 3 → WRITE.
- WRITE:
  - imem_waddr = word index and imem_wdata = assembled word; imem_we=1 for exactly one cycle.
  - Then the word index increments.
  - If the new index == word_count → CHECK, else → RECV.
- CHECK:
  - One byte is accepted. If it equals the running XOR → DONE, else → ERR.
  - The checksum byte is not XORed into the checksum.
- imem_waddr never exceeds IMEM_DEPTH-1, because the overflow check happens at start, so there is no wrap.
- DONE and ERR are sticky until start or reset1.
- Any byte presented while byte_ready=0 is not consumed; the source must hold it.

## Timing
- When the 4th byte of a word is accepted at edge N:
  - imem_we is high from edge N to edge N+1.
  - The memory commits the word at edge N+1.
  - byte_ready returns to 1 after edge N+1 (one bubble cycle per word).
- Maximum throughput is 4 bytes per 5 cycles. byte_valid gaps only stall the loader; no data is lost.
- Checksum byte accepted at edge M: done or err rises after edge M, and core_hold falls in the same cycle as done.
- Start accepted at edge S: byte_ready=1 from edge S (RECV or CHECK); err rises at edge S on overflow.
- reset1 asserted mid-load:
  - Outputs go to their reset values immediately (asynchronous) and any partial word is discarded.
  - Words already written stay in memory, but done is not reasserted without a new load.
- Outputs are registered and there is no combinational path from byte_valid to byte_ready.

## Test plan
- Load two words. start with word_count=2, then bytes b3 82 41 00 33 83 41 40, then checksum c1 → two writes: addr 0 = 0x004182b3, addr 1 = 0x40418333. done=1 and core_hold=0 after the checksum edge.
- Bad checksum. Same stream with checksum 00 → both words written, err=1, done=0, core_hold stays 1.
- Empty load. word_count=0, checksum 00 → no imem_we pulse, done=1 after one accepted byte.
- Overflow. word_count=513 → err=1 one cycle after start, byte_ready=0, no writes.
- Back-pressure and gaps. Random byte_valid gaps plus bytes offered during the WRITE bubble → each byte consumed exactly once, written words identical to the first scenario.
- Reset mid-load. reset1 after 6 of 8 bytes, then a new start with the first-scenario stream → state restarts at addr 0, final memory contents correct, done=1.
